// File: rtl/piso_serializer_if.sv
// Load-side valid/ready handshake for the parallel-in serial-out transmitter.
// The master drives a word and a valid flag; the slave answers with ready.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with framing strobes.
// Each shift step is gated by a bit_en tick.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  piso_serializer_if.slave    ld,
  input  logic                bit_en,
  output logic                sout,
  output logic                sout_valid,
  output logic                frame_start,
  output logic                frame_done,
  output logic                busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             sout_q, sout_d;
  logic             sv_q, sv_d;
  logic             fs_q, fs_d;
  logic             fd_q, fd_d;

  logic             accept;
  logic             last;
  logic             gap_last;
  logic             nxt_bit;
  logic [WIDTH-1:0] shreg_sh;

  assign accept   = ld.load_valid && (state_q == IDLE);
  assign last     = (cnt_q == CW'(WIDTH));
  assign gap_last = (gap_q == 4'(GAP_CYCLES - 1));

  always_comb begin
    if (MSB_FIRST) begin
      nxt_bit  = shreg_q[WIDTH-1];
      shreg_sh = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      nxt_bit  = shreg_q[0];
      shreg_sh = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      sout_q  <= 1'b0;
      sv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sout_q  <= sout_d;
      sv_q    <= sv_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = LOAD;
      LOAD:  if (bit_en) state_d = SHIFT;
      SHIFT: begin
        if (bit_en && last) begin
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP:   if (bit_en && gap_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sout_d  = sout_q;
    sv_d    = sv_q;
    fs_d    = 1'b0;
    fd_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        sout_d = 1'b0;
        sv_d   = 1'b0;
        if (accept) begin
          shreg_d = ld.data_in;
          cnt_d   = '0;
          gap_d   = '0;
        end
      end
      LOAD: begin
        if (bit_en) begin
          sout_d  = nxt_bit;
          shreg_d = shreg_sh;
          sv_d    = 1'b1;
          fs_d    = 1'b1;
          cnt_d   = CW'(1);
        end
      end
      SHIFT: begin
        if (bit_en && !last) begin
          sout_d  = nxt_bit;
          shreg_d = shreg_sh;
          cnt_d   = cnt_q + CW'(1);
        end else if (bit_en) begin
          // final bit-time ends: line drops and the frame closes
          sout_d = 1'b0;
          sv_d   = 1'b0;
          fd_d   = 1'b1;
          gap_d  = '0;
        end
      end
      GAP: begin
        sout_d = 1'b0;
        sv_d   = 1'b0;
        if (bit_en) gap_d = gap_q + 4'd1;
      end
      default: begin
        sout_d = 1'b0;
        sv_d   = 1'b0;
      end
    endcase
  end

  assign ld.load_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign sout          = sout_q;
  assign sout_valid    = sv_q;
  assign frame_start   = fs_q;
  assign frame_done    = fd_q;

endmodule
